// File: rtl/filter_cycle_ctrl.sv
// Two-pump filter loop sequencer: alternates fill pump A and return pump B on debounced floats.
// Optional command watchdog enabled by defining FILTER_CMD_WDT_EN.
module filter_cycle_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DEAD_CYCLES     = 8,
  parameter logic [23:0] FILL_TIMEOUT    = 24'd5_000_000,
  parameter logic [23:0] DRAIN_TIMEOUT   = 24'd5_000_000
`ifdef FILTER_CMD_WDT_EN
  ,
  parameter logic [23:0] CMD_WDT_CYCLES  = 24'd10_000_000
`endif
) (
  input  logic       clk_fpga,
  input  logic       reset_n,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_duty,
  output logic       o_cmd_ready,
  input  logic       i_boia_cheia,
  input  logic       i_boia_vazia,
  input  logic       i_fault_clr,
  output logic [7:0] o_duty_bomba_a,
  output logic [7:0] o_duty_bomba_b,
  output logic [2:0] o_state,
  output logic       o_fault
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    StStop      = 3'd0,
    StFilling   = 3'd1,
    StDtDrain   = 3'd2,
    StDraining  = 3'd3,
    StDtFill    = 3'd4,
    StStopping  = 3'd5,
    StFault     = 3'd6
  } state_e;

  // Float conditioning; bit 0 = cheia (full), bit 1 = vazia (empty).
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          deb_q, deb_d;
  logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 2'b10;
      sync2_q  <= 2'b10;
      deb_q    <= 2'b10;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= {i_boia_vazia, i_boia_cheia};
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end
    end
  end

  logic deb_cheia, deb_vazia, contra;
  assign deb_cheia = deb_q[0];
  assign deb_vazia = deb_q[1];
  assign contra    = deb_cheia & deb_vazia;

  // Sequencer state.
  state_e      state_q, state_d;
  logic [7:0]  duty_q, duty_d;
  logic        stop_q, stop_d;
  logic [23:0] timer_q, timer_d;
  logic [7:0]  duty_a_q, duty_a_d;
  logic [7:0]  duty_b_q, duty_b_d;
  logic        fault_q, fault_d;

  logic cmd_ready, cmd_acc, cmd_run, cmd_zero, wdt_hit;
  logic dead_done, fill_to, drain_to;

  always_comb begin
    cmd_ready = (state_q != StFault);
    cmd_acc   = i_cmd_valid & cmd_ready;
    cmd_run   = cmd_acc & (i_cmd_duty != 8'd0);
    // A watchdog expiry counts as a zero command unless a real command lands that cycle.
    cmd_zero  = cmd_acc ? (i_cmd_duty == 8'd0) : wdt_hit;
    dead_done = (timer_q >= 24'(DEAD_CYCLES - 1));
    fill_to   = (timer_q >= FILL_TIMEOUT - 24'd1);
    drain_to  = (timer_q >= DRAIN_TIMEOUT - 24'd1);
  end

`ifdef FILTER_CMD_WDT_EN
  logic [23:0] wdt_q, wdt_d;
  logic        wdt_active;

  always_comb begin
    wdt_active = (state_q == StFilling) || (state_q == StDraining) ||
                 (state_q == StDtDrain) || (state_q == StDtFill);
    wdt_hit    = wdt_active && (wdt_q >= CMD_WDT_CYCLES - 24'd1);
    wdt_d      = wdt_q;
    if (cmd_acc) begin
      wdt_d = '0;
    end else if (wdt_active && (wdt_q != 24'hFF_FFFF)) begin
      wdt_d = wdt_q + 24'd1;
    end
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    duty_d  = cmd_run ? i_cmd_duty : duty_q;

    unique case (state_q)
      StStop: begin
        if (cmd_run) state_d = StFilling;
      end
      StFilling: begin
        if (contra || fill_to) begin
          state_d = StFault;
        end else if (deb_cheia) begin
          state_d = StDtDrain;
          stop_d  = cmd_zero;
        end else if (cmd_zero) begin
          state_d = StStopping;
        end
      end
      StDtDrain: begin
        if (cmd_zero)     stop_d = 1'b1;
        else if (cmd_run) stop_d = 1'b0;
        if (contra) begin
          state_d = StFault;
        end else if (dead_done) begin
          state_d = stop_d ? StStopping : StDraining;
        end
      end
      StDraining: begin
        if (contra || drain_to) begin
          state_d = StFault;
        end else if (deb_vazia) begin
          state_d = StDtFill;
          stop_d  = cmd_zero;
        end else if (cmd_zero) begin
          state_d = StStopping;
        end
      end
      StDtFill: begin
        if (cmd_zero)     stop_d = 1'b1;
        else if (cmd_run) stop_d = 1'b0;
        if (contra) begin
          state_d = StFault;
        end else if (dead_done) begin
          state_d = stop_d ? StStop : StFilling;
        end
      end
      StStopping: begin
        if (contra || drain_to) begin
          state_d = StFault;
        end else if (deb_vazia) begin
          state_d = StStop;
        end else if (cmd_run) begin
          state_d = StDraining;
        end
      end
      StFault: begin
        if (i_fault_clr) begin
          state_d = StStop;
          stop_d  = 1'b0;
        end
      end
      default: begin
        state_d = StFault;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != 24'hFF_FFFF) begin
      timer_d = timer_q + 24'd1;
    end else begin
      timer_d = timer_q;
    end

    // Outputs follow the next state so they register on the same edge as the transition.
    duty_a_d = 8'd0;
    duty_b_d = 8'd0;
    if (state_d == StFilling) begin
      duty_a_d = duty_d;
    end else if ((state_d == StDraining) || (state_d == StStopping)) begin
      duty_b_d = duty_d;
    end
    fault_d = (state_d == StFault);
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StStop;
      duty_q   <= 8'd0;
      stop_q   <= 1'b0;
      timer_q  <= '0;
      duty_a_q <= 8'd0;
      duty_b_q <= 8'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      stop_q   <= stop_d;
      timer_q  <= timer_d;
      duty_a_q <= duty_a_d;
      duty_b_q <= duty_b_d;
      fault_q  <= fault_d;
    end
  end

  assign o_cmd_ready    = cmd_ready;
  assign o_duty_bomba_a = duty_a_q;
  assign o_duty_bomba_b = duty_b_q;
  assign o_state        = state_q;
  assign o_fault        = fault_q;

endmodule

// File: tb/tb_filter_cycle_ctrl.sv
// Directed bench for filter_cycle_ctrl: vector table for the normal cycle, hand sequences for
// timeout, contradiction, glitch, async reset and (with FILTER_CMD_WDT_EN) the command watchdog.
module tb_filter_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_duty;
  logic       cmd_ready;
  logic       cheia, vazia, fault_clr;
  logic [7:0] duty_a, duty_b;
  logic [2:0] state;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  filter_cycle_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DEAD_CYCLES    (3),
    .FILL_TIMEOUT   (24'd200),
    .DRAIN_TIMEOUT  (24'd200)
`ifdef FILTER_CMD_WDT_EN
    ,
    .CMD_WDT_CYCLES (24'd100)
`endif
  ) dut (
    .clk_fpga      (clk),
    .reset_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .i_cmd_duty    (cmd_duty),
    .o_cmd_ready   (cmd_ready),
    .i_boia_cheia  (cheia),
    .i_boia_vazia  (vazia),
    .i_fault_clr   (fault_clr),
    .o_duty_bomba_a(duty_a),
    .o_duty_bomba_b(duty_b),
    .o_state       (state),
    .o_fault       (fault)
  );

  typedef struct {
    int unsigned ncyc;
    logic        valid;
    logic [7:0]  duty;
    logic        cheia;
    logic        vazia;
    logic [2:0]  st;
    logic [7:0]  a;
    logic [7:0]  b;
  } vec_t;

  vec_t vecs[25];

  task automatic cmp(input string name, input string field, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", name, field, got, want);
    end
  endtask

  task automatic check(input string name, input int st, input int a, input int b,
                       input int f, input int r);
    cmp(name, "state", int'(state), st);
    cmp(name, "duty_a", int'(duty_a), a);
    cmp(name, "duty_b", int'(duty_b), b);
    cmp(name, "fault", int'(fault), f);
    cmp(name, "ready", int'(cmd_ready), r);
  endtask

  task automatic check_excl();
    n_checks++;
    if ((duty_a != 8'd0) && (duty_b != 8'd0)) begin
      n_fail++;
      $display("FAIL pump_exclusive: a=%0d b=%0d, expected one of them 0", duty_a, duty_b);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_excl();
    end
  endtask

  task automatic send(input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    step(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1, 1'b1, 8'd230, 1'b0, 1'b1, 3'd1, 8'd230, 8'd0};
    vecs[1]  = '{5, 1'b0, 8'd0,   1'b1, 1'b0, 3'd1, 8'd230, 8'd0};
    vecs[2]  = '{1, 1'b0, 8'd0,   1'b1, 1'b0, 3'd1, 8'd230, 8'd0};
    vecs[3]  = '{1, 1'b0, 8'd0,   1'b1, 1'b0, 3'd2, 8'd0,   8'd0};
    vecs[4]  = '{2, 1'b0, 8'd0,   1'b1, 1'b0, 3'd2, 8'd0,   8'd0};
    vecs[5]  = '{1, 1'b0, 8'd0,   1'b1, 1'b0, 3'd3, 8'd0,   8'd230};
    vecs[6]  = '{6, 1'b0, 8'd0,   1'b0, 1'b1, 3'd3, 8'd0,   8'd230};
    vecs[7]  = '{1, 1'b0, 8'd0,   1'b0, 1'b1, 3'd4, 8'd0,   8'd0};
    vecs[8]  = '{2, 1'b0, 8'd0,   1'b0, 1'b1, 3'd4, 8'd0,   8'd0};
    vecs[9]  = '{1, 1'b0, 8'd0,   1'b0, 1'b1, 3'd1, 8'd230, 8'd0};
    vecs[10] = '{7, 1'b0, 8'd0,   1'b1, 1'b0, 3'd2, 8'd0,   8'd0};
    vecs[11] = '{3, 1'b0, 8'd0,   1'b1, 1'b0, 3'd3, 8'd0,   8'd230};
    vecs[12] = '{1, 1'b1, 8'd0,   1'b1, 1'b0, 3'd5, 8'd0,   8'd230};
    vecs[13] = '{6, 1'b0, 8'd0,   1'b0, 1'b1, 3'd5, 8'd0,   8'd230};
    vecs[14] = '{1, 1'b0, 8'd0,   1'b0, 1'b1, 3'd0, 8'd0,   8'd0};
    vecs[15] = '{1, 1'b1, 8'd0,   1'b0, 1'b1, 3'd0, 8'd0,   8'd0};
    vecs[16] = '{1, 1'b1, 8'd77,  1'b0, 1'b1, 3'd1, 8'd77,  8'd0};
    vecs[17] = '{1, 1'b1, 8'd128, 1'b0, 1'b1, 3'd1, 8'd128, 8'd0};
    vecs[18] = '{1, 1'b1, 8'd0,   1'b0, 1'b1, 3'd5, 8'd0,   8'd128};
    vecs[19] = '{1, 1'b0, 8'd0,   1'b0, 1'b1, 3'd0, 8'd0,   8'd0};
    vecs[20] = '{1, 1'b1, 8'd90,  1'b0, 1'b1, 3'd1, 8'd90,  8'd0};
    vecs[21] = '{7, 1'b0, 8'd0,   1'b1, 1'b0, 3'd2, 8'd0,   8'd0};
    vecs[22] = '{1, 1'b1, 8'd0,   1'b1, 1'b0, 3'd2, 8'd0,   8'd0};
    vecs[23] = '{2, 1'b0, 8'd0,   1'b1, 1'b0, 3'd5, 8'd0,   8'd90};
    vecs[24] = '{7, 1'b0, 8'd0,   1'b0, 1'b1, 3'd0, 8'd0,   8'd0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_duty  = 8'd0;
    cheia     = 1'b0;
    vazia     = 1'b1;
    fault_clr = 1'b0;
    #23;
    check("reset_hold", 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    check("reset_release", 0, 0, 0, 0, 1);

    // Normal cycle, stop while draining, duty update, stop in dead time.
    for (int v = 0; v < 25; v++) begin
      cmd_valid = vecs[v].valid;
      cmd_duty  = vecs[v].duty;
      cheia     = vecs[v].cheia;
      vazia     = vecs[v].vazia;
      step(int'(vecs[v].ncyc));
      check($sformatf("vec%0d", v), int'(vecs[v].st), int'(vecs[v].a), int'(vecs[v].b), 0, 1);
    end
    cmd_valid = 1'b0;

    // Dry-run fill timeout; periodic refresh keeps any command watchdog quiet.
    send(8'd200);
    check("tmo_fill", 1, 200, 0, 0, 1);
    for (int i = 1; i < 200; i++) begin
      cmd_valid = (i % 50 == 0);
      step(1);
    end
    cmd_valid = 1'b0;
    check("tmo_before", 1, 200, 0, 0, 1);
    step(1);
    check("tmo_fault", 6, 0, 0, 1, 0);
    send(8'd99);
    check("fault_ignores_cmd", 6, 0, 0, 1, 0);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("fault_clear", 0, 0, 0, 0, 1);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("clr_in_stop", 0, 0, 0, 0, 1);

    // Sensor contradiction while filling.
    send(8'd100);
    check("contra_fill", 1, 100, 0, 0, 1);
    cheia = 1'b1;
    step(6);
    check("contra_before", 1, 100, 0, 0, 1);
    step(1);
    check("contra_fault", 6, 0, 0, 1, 0);
    cheia     = 1'b0;
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("contra_clear", 0, 0, 0, 0, 1);
    step(8);

    // Two-cycle cheia glitch must be filtered.
    send(8'd100);
    cheia = 1'b1;
    step(2);
    cheia = 1'b0;
    step(10);
    check("glitch_ignored", 1, 100, 0, 0, 1);
    send(8'd0);
    check("glitch_stop", 5, 0, 100, 0, 1);
    step(1);
    check("glitch_idle", 0, 0, 0, 0, 1);

    // Asynchronous reset while draining.
    send(8'd150);
    cheia = 1'b1;
    vazia = 1'b0;
    step(7);
    check("rst_dtdrain", 2, 0, 0, 0, 1);
    step(3);
    check("rst_draining", 3, 0, 150, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 0, 0, 0, 0, 1);
    cheia = 1'b0;
    vazia = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("rst_after", 0, 0, 0, 0, 1);
    send(8'd50);
    check("rst_fresh_cmd", 1, 50, 0, 0, 1);
    send(8'd0);
    check("rst_stop", 5, 0, 50, 0, 1);
    step(1);
    check("rst_idle", 0, 0, 0, 0, 1);

`ifdef FILTER_CMD_WDT_EN
    send(8'd60);
    step(99);
    check("wdt_before", 1, 60, 0, 0, 1);
    step(1);
    check("wdt_stopping", 5, 0, 60, 0, 1);
    step(1);
    check("wdt_idle", 0, 0, 0, 0, 1);
`else
    send(8'd60);
    step(150);
    check("no_wdt_fill", 1, 60, 0, 0, 1);
    send(8'd0);
    check("no_wdt_stop", 5, 0, 60, 0, 1);
    step(1);
    check("no_wdt_idle", 0, 0, 0, 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_cycle_ctrl.md
Name: filter_cycle_ctrl

Overview:
- Tactical sequencer for the two-pump filter loop.
- Accepts a PWM duty command from the BitDogLab handshake receiver, which is already in the clk_fpga domain.
- Alternates fill pump A and return pump B using debounced float sensors (boias), and drains the filter fully on stop.
- Drives duty words to the downstream PWM generators and protects the pumps against dry-run and stuck sensors.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a float level change
DEAD_CYCLES, 8, both-pumps-off gap at every A/B changeover
FILL_TIMEOUT, 24'd5_000_000, max cycles in FILLING before FAULT
DRAIN_TIMEOUT, 24'd5_000_000, max cycles in DRAINING/STOPPING before FAULT

Ports:
clk_fpga  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  duty command present
i_cmd_duty  in  8  requested duty; 0 = stop
o_cmd_ready  out  1  command accepted on the edge where valid&ready
i_boia_cheia  in  1  raw full float, asynchronous
i_boia_vazia  in  1  raw empty float, asynchronous
i_fault_clr  in  1  single-cycle fault acknowledge
o_duty_bomba_a  out  8  fill pump duty
o_duty_bomba_b  out  8  return pump duty
o_state  out  3  current state code
o_fault  out  1  fault latched

Behaviour:
- Reset (async assert, sync release): state=STOP, duty_reg=0, both duty outputs=0, o_fault=0, o_cmd_ready=1, debounced cheia=0, debounced vazia=1, all counters=0.
- Float inputs: 2-FF synchronizer, then per-input debounce counter. The debounced value flips after the input has been stable DEBOUNCE_CYCLES cycles. Total sensor latency is 2+DEBOUNCE_CYCLES cycles.
- Command accept: o_cmd_ready=1 in every state except FAULT. A command is accepted on the edge where i_cmd_valid&o_cmd_ready. The state update and duty outputs take effect on that same edge, so they are visible the following cycle.
- Nonzero command: load duty_reg. While running, only the duty value changes; there is no state change.
- Zero command: sets stop intent. duty_reg keeps the last nonzero value so the final drain can run.
- State codes: STOP=0, FILLING=1, DT_DRAIN=2, DRAINING=3, DT_FILL=4, STOPPING=5, FAULT=6.
- STOP: A=0, B=0.
  - Nonzero command -> FILLING.
  - Zero command -> stay in STOP.
- FILLING: A=duty_reg, B=0.
  - Debounced cheia -> DT_DRAIN.
  - Zero command -> STOPPING.
  - Timer reaching FILL_TIMEOUT -> FAULT.
- DT_DRAIN: A=0, B=0 for DEAD_CYCLES, then DRAINING.
- DRAINING: A=0, B=duty_reg.
  - Debounced vazia -> DT_FILL.
  - Zero command -> STOPPING.
  - Timer reaching DRAIN_TIMEOUT -> FAULT.
- DT_FILL: A=0, B=0 for DEAD_CYCLES, then FILLING.
  - If a zero command was accepted during either dead time: DT_FILL exits to STOP, and DT_DRAIN exits to STOPPING.
- STOPPING: A=0, B=duty_reg.
  - Debounced vazia -> STOP.
  - Nonzero command -> DRAINING with the new duty (resume).
  - Timer reaching DRAIN_TIMEOUT -> FAULT.
- FAULT: A=0, B=0, o_fault=1, o_cmd_ready=0.
  - i_fault_clr -> STOP and clear o_fault.
  - i_fault_clr is ignored in all other states.
- Sensor contradiction: debounced cheia=1 AND vazia=1 in any state other than STOP/FAULT -> FAULT on the next edge. Contradiction has priority over command and level transitions.
- Priority in one cycle: contradiction > timeout > level transition > command.
- State timer: 24-bit, cleared on every state entry, saturating.
- Pumps A and B must never be nonzero in the same cycle. This is asserted in verification.
- Reset mid-operation: outputs go to 0 immediately (asynchronously). No pending command or stop intent survives reset.

Optional Feature:
FILTER_CMD_WDT_EN:
- Defined: adds parameter CMD_WDT_CYCLES (default 24'd10_000_000).
  - A counter is cleared by each accepted command.
  - If it reaches CMD_WDT_CYCLES in FILLING, DRAINING, DT_DRAIN or DT_FILL, the block behaves exactly as if a zero command had been accepted (loss of host -> safe drain to STOP).
  - The counter is frozen in STOP, STOPPING and FAULT.
- Undefined: no watchdog logic; commands only change on host request.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, DEAD_CYCLES=3, FILL_TIMEOUT=DRAIN_TIMEOUT=200.
1. Normal cycle: reset; cmd 230 accepted -> A=230, B=0, state=1. Raise cheia -> 6 cycles later state=2, A=B=0 for 3 cycles, then B=230. Drop cheia, raise vazia -> DT_FILL, then A=230.
2. Stop while draining: in DRAINING send cmd 0 -> state=5, B stays 230. Vazia asserted -> after 6 cycles state=0, A=B=0.
3. Duty update: in FILLING send cmd 128 -> next cycle A=128, state unchanged. Send cmd 0 in STOP -> remains 0.
4. Dry-run timeout: cmd 200, hold cheia=0 -> after 200 cycles state=6, o_fault=1, o_cmd_ready=0, A=B=0. Pulse i_fault_clr -> state=0.
5. Contradiction and glitch: both floats=1 stable in FILLING -> FAULT. A 2-cycle cheia pulse causes no transition.
6. Async reset in DRAINING: reset_n low -> outputs 0 before the next edge. After release: state=0, a fresh cmd 50 gives A=50. With FILTER_CMD_WDT_EN and CMD_WDT_CYCLES=100: no command for 100 cycles in FILLING -> STOPPING.
